// File: rtl/io_map_pkg.sv
// Address map, STATUS bit layout and a STATUS word builder for io_responder.
package io_map_pkg;

    localparam logic [7:0] IO_PAGE = 8'hFF;

    localparam logic [7:0] OFS_LED    = 8'h00;
    localparam logic [7:0] OFS_SW     = 8'h04;
    localparam logic [7:0] OFS_TXDATA = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_RXDATA = 8'h10;
    localparam logic [7:0] OFS_TIMER  = 8'h14;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_VALID = 2;
    localparam int unsigned ST_TX_OVF   = 3;
    localparam int unsigned ST_RX_OVR   = 4;
    localparam int unsigned ST_TMR_DONE = 5;

    function automatic logic [31:0] status_word(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_valid,
        input logic tx_ovf,
        input logic rx_ovr,
        input logic tmr_done
    );
        logic [31:0] w;
        w              = '0;
        w[ST_TX_FULL]  = tx_full;
        w[ST_TX_EMPTY] = tx_empty;
        w[ST_RX_VALID] = rx_valid;
        w[ST_TX_OVF]   = tx_ovf;
        w[ST_RX_OVR]   = rx_ovr;
        w[ST_TMR_DONE] = tmr_done;
        return w;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU-side I/O bus between the data-memory unit (master) and io_responder (slave).
interface io_responder_if;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (
        output io_addr,
        output io_dout,
        output io_we,
        output io_rd,
        input  io_din
    );

    modport slave (
        input  io_addr,
        input  io_dout,
        input  io_we,
        input  io_rd,
        output io_din
    );
endinterface

// File: rtl/io_tx_fifo.sv
// Circular byte FIFO for the TX egress path; a push while full is accepted only
// when a pop happens in the same cycle.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    // Head reads 0 while empty so stale storage never leaks onto tx_data.
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O page 0xFFxx: LED, switches, TX FIFO, RX holding register, timer.
// Define IO_TIMER_EN to build the countdown timer; otherwise TIMER reads 0.
module io_responder
    import io_map_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned LED_W    = 16,
    parameter int unsigned SW_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    io_responder_if.slave    io,
    output logic [LED_W-1:0] led_o,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_stb_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i
);
    logic       sel, wr_en, rd_en;
    logic [7:0] ofs;
    logic       wr_led, wr_tx, wr_status, wr_timer, rd_rx;

    assign sel       = (io.io_addr[15:8] == IO_PAGE);
    assign ofs       = io.io_addr[7:0];
    assign wr_en     = sel && io.io_we;
    assign rd_en     = sel && io.io_rd;
    assign wr_led    = wr_en && (ofs == OFS_LED);
    assign wr_tx     = wr_en && (ofs == OFS_TXDATA);
    assign wr_status = wr_en && (ofs == OFS_STATUS);
    assign wr_timer  = wr_en && (ofs == OFS_TIMER);
    assign rd_rx     = rd_en && (ofs == OFS_RXDATA);

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [7:0]       rx_hold_q, rx_hold_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             tx_full, tx_empty, tx_pop;
    logic [31:0]      tmr_cnt;
    logic             tmr_done;
    logic [31:0]      rdata;

    assign tx_pop     = !tx_empty && tx_ready_i;
    assign tx_valid_o = !tx_empty;
    assign led_o      = led_q;

    io_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (wr_tx),
        .data_i  (io.io_dout[7:0]),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_data_o)
    );

    always_comb begin
        led_d      = led_q;
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        tx_ovf_d   = tx_ovf_q;
        if (wr_led) led_d = io.io_dout[LED_W-1:0];
        // W1C clears first so a same-cycle set event wins.
        if (wr_status && io.io_dout[ST_TX_OVF]) tx_ovf_d = 1'b0;
        if (wr_status && io.io_dout[ST_RX_OVR]) rx_ovr_d = 1'b0;
        if (wr_tx && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        if (rx_stb_i) begin
            rx_hold_d  = rx_data_i;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rd_rx) rx_ovr_d = 1'b1;
        end else if (rd_rx) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q      <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
        end else begin
            led_q      <= led_d;
            sw_s1_q    <= sw_i;
            sw_s2_q    <= sw_s1_q;
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

`ifdef IO_TIMER_EN
    logic [31:0] tmr_cnt_q, tmr_cnt_d;
    logic        tmr_done_q, tmr_done_d;

    always_comb begin
        tmr_cnt_d  = tmr_cnt_q;
        tmr_done_d = tmr_done_q;
        if (wr_status && io.io_dout[ST_TMR_DONE]) tmr_done_d = 1'b0;
        if (wr_timer) begin
            tmr_cnt_d = io.io_dout;
        end else if (tmr_cnt_q != '0) begin
            tmr_cnt_d = tmr_cnt_q - 32'd1;
            if (tmr_cnt_q == 32'd1) tmr_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmr_cnt_q  <= '0;
            tmr_done_q <= 1'b0;
        end else begin
            tmr_cnt_q  <= tmr_cnt_d;
            tmr_done_q <= tmr_done_d;
        end
    end

    assign tmr_cnt  = tmr_cnt_q;
    assign tmr_done = tmr_done_q;
`else
    logic unused_dout;
    assign unused_dout = ^{io.io_dout, wr_timer};
    assign tmr_cnt     = '0;
    assign tmr_done    = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (ofs)
                OFS_LED:    rdata = 32'(led_q);
                OFS_SW:     rdata = 32'(sw_s2_q);
                OFS_STATUS: rdata = status_word(tx_full, tx_empty, rx_valid_q, tx_ovf_q,
                                                rx_ovr_q, tmr_done);
                OFS_RXDATA: rdata = {24'h0, rx_hold_q};
                OFS_TIMER:  rdata = tmr_cnt;
                default:    rdata = '0;
            endcase
        end
    end

    assign io.io_din = rdata;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: directed scenarios plus random bus/RX/TX traffic
// against a queue-based reference model.
module tb_io_responder;

`ifdef IO_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif
    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] led;
    logic [15:0] sw = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    bit          rdy = 1'b0;

    always #5 clk = ~clk;

    io_responder_if bus ();

    io_responder #(
        .TX_DEPTH (Depth),
        .LED_W    (16),
        .SW_W     (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .io         (bus),
        .led_o      (led),
        .sw_i       (sw),
        .rx_data_i  (rx_data),
        .rx_stb_i   (rx_stb),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_led, m_s1, m_s2;
    logic [7:0]  m_fifo[$];
    logic [7:0]  m_rxh;
    bit          m_rxv, m_ovr, m_ovf, m_done;
    logic [31:0] m_cnt;

    logic [31:0] rdq[$];
    logic [7:0]  txq[$];

    task automatic model_reset();
        m_led = '0; m_s1 = '0; m_s2 = '0; m_fifo.delete(); m_rxh = '0;
        m_rxv = 0; m_ovr = 0; m_ovf = 0; m_done = 0; m_cnt = '0;
    endtask

    function automatic logic [31:0] mread(input logic [15:0] a);
        if (a[15:8] != 8'hFF) return 32'h0;
        case (a[7:0])
            8'h00: return {16'h0, m_led};
            8'h04: return {16'h0, m_s2};
            8'h0C: return {26'h0, m_done, m_ovr, m_ovf, m_rxv,
                           m_fifo.size() == 0, m_fifo.size() == Depth};
            8'h10: return {24'h0, m_rxh};
            8'h14: return TimerEn ? m_cnt : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic commit(input logic [15:0] a, input logic [31:0] d, input bit we,
                          input bit rd, input bit stb, input logic [7:0] rxd, input bit rdy_i);
        bit sel, w, rx_read;
        logic [7:0] o;
        sel = (a[15:8] == 8'hFF);
        o = a[7:0];
        w = we && sel;
        rx_read = rd && sel && (o == 8'h10);
        if (rdy_i && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (w && o == 8'h0C) begin
            if (d[3]) m_ovf = 0;
            if (d[4]) m_ovr = 0;
            if (d[5]) m_done = 0;
        end
        if (w && o == 8'h08) begin
            if (m_fifo.size() < Depth) m_fifo.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (w && o == 8'h00) m_led = d[15:0];
        if (stb) begin
            if (m_rxv && !rx_read) m_ovr = 1;
            m_rxh = rxd;
            m_rxv = 1;
        end else if (rx_read) begin
            m_rxv = 0;
        end
        if (TimerEn) begin
            if (w && o == 8'h14) m_cnt = d;
            else if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_done = 1;
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    // One bus cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic [15:0] a, input logic [31:0] d, input bit we, input bit rd,
                        input bit stb, input logic [7:0] rxd);
        bus.io_addr = a; bus.io_dout = d; bus.io_we = we; bus.io_rd = rd;
        rx_stb = stb; rx_data = rxd; tx_ready = rdy;
        if (rd) rdq.push_back(mread(a));
        if (rdy && m_fifo.size() != 0) txq.push_back(m_fifo[0]);
        @(posedge clk);
        commit(a, d, we, rd, stb, rxd, rdy);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        step(a, d, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [15:0] a);
        step(a, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic stb(input logic [7:0] b);
        step(16'h0000, 32'h0, 1'b0, 1'b0, 1'b1, b);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.io_rd) begin
                if (rdq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_unexpected: got read with empty scoreboard, required none");
                end else begin
                    check("io_din", bus.io_din, rdq.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, required no handshake", tx_data);
                end else begin
                    check("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        int k;
        bus.io_addr = '0; bus.io_dout = '0; bus.io_we = 1'b0; bus.io_rd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        rd(16'hFF0C);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);

        // LED write/read, off-page write ignored, read-during-write returns old value
        wr(16'hFF00, 32'h1234ABCD);
        check("led_write", {16'h0, led}, 32'h0000ABCD);
        rd(16'hFF00);
        wr(16'hFE00, 32'h00005555);
        check("led_offpage", {16'h0, led}, 32'h0000ABCD);
        rd(16'hFE00);
        step(16'hFF00, 32'h00000F0F, 1'b1, 1'b1, 1'b0, 8'h00);
        rd(16'hFF00);
        rd(16'hFF08);
        rd(16'hFF18);

        // Reset mid-operation with 3 bytes queued
        rdy = 1'b0;
        wr(16'hFF08, 32'hA1); wr(16'hFF08, 32'hA2); wr(16'hFF08, 32'hA3);
        rstn = 1'b0;
        bus.io_we = 1'b0; bus.io_rd = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        rstn = 1'b1;
        rd(16'hFF0C);

        // FIFO overflow then drain in order
        for (int i = 0; i < 5; i++) wr(16'hFF08, 32'h11 + i);
        rd(16'hFF0C);
        check("fifo_head", {24'h0, tx_data}, 32'h11);
        rdy = 1'b1;
        idle(6);
        check("fifo_drained", {31'h0, tx_valid}, 32'h0);
        wr(16'hFF0C, 32'h08);
        rd(16'hFF0C);
        // Full FIFO with a same-cycle pop accepts the push
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'hFF08, 32'h20 + i);
        rdy = 1'b1;
        wr(16'hFF08, 32'h24);
        rdy = 1'b0;
        rd(16'hFF0C);
        rdy = 1'b1;
        idle(6);

        // RX overrun, read clears valid, coincident strobe+read has no overrun
        stb(8'h5A); stb(8'h77);
        rd(16'hFF0C); rd(16'hFF10); rd(16'hFF0C);
        wr(16'hFF0C, 32'h10);
        stb(8'h33);
        step(16'hFF10, 32'h0, 1'b0, 1'b1, 1'b1, 8'h44);
        rd(16'hFF0C); rd(16'hFF10); rd(16'hFF0C);

        // Timer countdown, reload, and set-vs-W1C race
        wr(16'hFF14, 32'd3);
        for (int i = 0; i < 4; i++) begin rd(16'hFF14); rd(16'hFF0C); end
        wr(16'hFF0C, 32'h20);
        wr(16'hFF14, 32'd10);
        idle(7);
        rd(16'hFF14);
        wr(16'hFF14, 32'd5);
        rd(16'hFF14);
        wr(16'hFF14, 32'd1);
        wr(16'hFF0C, 32'h20);
        rd(16'hFF0C);
        wr(16'hFF0C, 32'h20);
        wr(16'hFF14, 32'd0);
        rd(16'hFF0C);

        // Switch synchroniser: old value one edge after change, new value from the third
        sw = 16'hF0F0;
        rd(16'hFF04); rd(16'hFF04); idle(1); rd(16'hFF04);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            k = int'($urandom_range(0, 9));
            if (k <= 5) a = {8'hFF, 8'(k * 4)};
            else if (k == 6) a = 16'hFF18;
            else if (k == 7) a = {8'($urandom_range(0, 254)), 8'(4 * $urandom_range(0, 5))};
            else a = 16'hFF08;
            d = $urandom;
            if (a == 16'hFF14) d = $urandom_range(0, 12);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
            step(a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, 8'($urandom));
        end
        rdy = 1'b1;
        idle(6);
        rd(16'hFF0C);
        check("queues_drained", rdq.size() + txq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
